// File: rtl/pc_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_down_counter
// Description : Loadable synchronous down-counter with terminal-count pulse,
//               complemented output and optional periodic auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_down_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] qout,
    output logic [WIDTH-1:0] qnout,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_done;
    logic             w_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= c_zero;
            r_reload <= c_zero;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            if (load_val == c_zero) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else if ((r_state == S_RUN) && en) begin
            if (r_count > c_one) begin
                w_count_nxt = r_count - c_one;
            end else if (r_count == c_one) begin
                w_count_nxt = c_zero;
                w_done_nxt  = 1'b1;
                w_state_nxt = AUTO_RELOAD ? S_RUN : S_DONE;
            end else begin
                // Count sits at zero only in auto-reload mode; restart the loop.
                w_count_nxt = r_reload;
            end
        end
    end

    assign qout  = r_count;
    assign qnout = ~r_count;
    assign zero  = (r_count == c_zero);
    assign busy  = (r_state == S_RUN);
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pc_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_down_counter
// Description : Self-checking bench; runs a stop-at-zero and an auto-reload
//               instance side by side against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;

    logic [W-1:0] q0, qn0, q1, qn1;
    logic         z0, b0, d0, z1, b1, d1;

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance: index 0 stops at zero, index 1 auto-reloads.
    int m_q[2];
    int m_rl[2];
    bit m_run[2];
    bit m_done[2];

    always #5 clk = ~clk;

    pc_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .qout(q0), .qnout(qn0), .zero(z0), .busy(b0), .done(d0)
    );

    pc_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .qout(q1), .qnout(qn1), .zero(z1), .busy(b1), .done(d1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int d, input bit ar);
        if (reset) begin
            m_q[d] = 0; m_rl[d] = 0; m_run[d] = 0; m_done[d] = 0;
        end else if (load) begin
            m_q[d]    = int'(load_val);
            m_rl[d]   = int'(load_val);
            m_run[d]  = (load_val != 0);
            m_done[d] = (load_val == 0);
        end else begin
            m_done[d] = 0;
            if (m_run[d] && en) begin
                if (m_q[d] == 0)      m_q[d] = m_rl[d];
                else begin
                    m_q[d] = m_q[d] - 1;
                    if (m_q[d] == 0) begin
                        m_done[d] = 1;
                        m_run[d]  = ar;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [W-1:0] q, input logic [W-1:0] qn,
                             input logic z, input logic b, input logic dn);
        check($sformatf("d%0d_qout", d),  32'(q),  32'(m_q[d]));
        check($sformatf("d%0d_qnout", d), 32'(qn), 32'((~m_q[d]) & ((1 << W) - 1)));
        check($sformatf("d%0d_zero", d),  32'(z),  32'(m_q[d] == 0));
        check($sformatf("d%0d_busy", d),  32'(b),  32'(m_run[d]));
        check($sformatf("d%0d_done", d),  32'(dn), 32'(m_done[d]));
    endtask

    task automatic step(input bit r, input bit l, input int lv, input bit e);
        @(negedge clk);
        reset    = r;
        load     = l;
        load_val = W'(lv);
        en       = e;
        @(posedge clk);
        model_edge(0, 1'b0);
        model_edge(1, 1'b1);
        #1;
        check_dut(0, q0, qn0, z0, b0, d0);
        check_dut(1, q1, qn1, z1, b1, d1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_rl[i] = 0; m_run[i] = 0; m_done[i] = 0;
        end

        step(1, 0, 0, 0);
        step(1, 1, 7, 1);
        check("reset_qnout", 32'(qn0), 32'hF);

        // Load 3 then count down to terminal.
        step(0, 1, 3, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("stop_at_zero_q", 32'(q0), 32'h0);
        check("stop_busy_low", 32'(b0), 32'h0);

        // Auto-reload loop of period 3.
        step(0, 1, 2, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        check("reload_busy", 32'(b1), 32'h1);

        // Enable gaps hold the count.
        step(0, 1, 5, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("gap_q", 32'(q0), 32'h3);

        // Load wins over enable.
        step(0, 1, 2, 0);
        step(0, 1, 9, 1);
        check("load_wins_q", 32'(q0), 32'h9);

        // Load zero, then enable must not wrap.
        step(0, 1, 0, 0);
        check("load0_done", 32'(d0), 32'h1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("no_wrap_q", 32'(q0), 32'h0);

        // Back-to-back zero loads give consecutive done pulses.
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);

        // Reset mid-run at count 1 suppresses the terminal pulse.
        step(0, 1, 1, 0);
        step(1, 0, 0, 1);
        check("rst_mid_done", 32'(d0), 32'h0);
        check("rst_mid_qnout", 32'(qn0), 32'hF);

        // Randomized traffic biased toward small loads to hit terminal counts often.
        for (int i = 0; i < 3000; i++) begin
            int  rr, rl, lv;
            bit  e;
            rr = $urandom_range(0, 99);
            rl = $urandom_range(0, 99);
            lv = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            e  = ($urandom_range(0, 9) < 7);
            step(rr < 2, rl < 10, lv, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
